// File: rtl/if_pkg.sv
// Shared defaults and constants for the instruction fetch queue.
package if_pkg;

   localparam int unsigned AW_DEF       = 32;
   localparam int unsigned IW_DEF       = 32;
   localparam int unsigned DEPTH_DEF    = 4;
   localparam logic [63:0] RESET_PC_DEF = 64'h0;
   localparam int unsigned PC_INC       = 4;

endpackage : if_pkg

// File: rtl/if_fetch_queue_if.sv
// Fetch queue bus: redirect, instruction memory side and decode side.
interface if_fetch_queue_if #(
   parameter int unsigned AW = 32,
   parameter int unsigned IW = 32
);

   logic          REDIRECT;
   logic [AW-1:0] REDIRECT_PC;
   logic          IREQ;
   logic [AW-1:0] IADDR;
   logic          IVALID;
   logic [IW-1:0] IRDATA;
   logic          INST_VALID;
   logic [IW-1:0] INST;
   logic [AW-1:0] INST_PC;
   logic          INST_READY;
   logic          ERR;

   // Fetch queue view.
   modport slave (
      input  REDIRECT, REDIRECT_PC, IVALID, IRDATA, INST_READY,
      output IREQ, IADDR, INST_VALID, INST, INST_PC, ERR
   );

   // Environment view (pipeline control, memory, decode).
   modport master (
      output REDIRECT, REDIRECT_PC, IVALID, IRDATA, INST_READY,
      input  IREQ, IADDR, INST_VALID, INST, INST_PC, ERR
   );

endinterface : if_fetch_queue_if

// File: rtl/if_inst_fifo.sv
// Circular instruction buffer with flush; pointers wrap modulo DEPTH.
module if_inst_fifo #(
   parameter int unsigned IW    = 32,
   parameter int unsigned DEPTH = 4
) (
   input  logic                         CLK,
   input  logic                         RSTN,
   input  logic                         push,
   input  logic                         pop,
   input  logic                         flush,
   input  logic [IW-1:0]                wr_data,
   output logic [IW-1:0]                rd_data,
   output logic [$clog2(DEPTH+1)-1:0]   occ
);

   localparam int unsigned PW = $clog2(DEPTH);
   localparam int unsigned CW = $clog2(DEPTH+1);

   logic [IW-1:0] mem [DEPTH];
   logic [PW-1:0] wr_ptr;
   logic [PW-1:0] rd_ptr;

   // Pointer and occupancy tracking; flush empties the buffer.
   always_ff @(posedge CLK or negedge RSTN) begin
      if (!RSTN) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         occ    <= '0;
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         occ    <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + PW'(1);
         if (pop)  rd_ptr <= rd_ptr + PW'(1);
         case ({push, pop})
            2'b10:   occ <= occ + CW'(1);
            2'b01:   occ <= occ - CW'(1);
            default: occ <= occ;
         endcase
      end
   end

   // Storage array; contents need no reset since occ gates visibility.
   always_ff @(posedge CLK) begin
      if (push && !flush) mem[wr_ptr] <= wr_data;
   end

   assign rd_data = mem[rd_ptr];

endmodule : if_inst_fifo

// File: rtl/if_fetch_queue.sv
// Instruction fetch queue: issues sequential fetches, tracks in-flight
// responses, discards responses made stale by a redirect, buffers the rest.
module if_fetch_queue
   import if_pkg::*;
#(
   parameter int unsigned   AW       = AW_DEF,
   parameter int unsigned   IW       = IW_DEF,
   parameter int unsigned   DEPTH    = DEPTH_DEF,
   parameter logic [AW-1:0] RESET_PC = AW'(RESET_PC_DEF)
) (
   input  logic              CLK,
   input  logic              RSTN,
   if_fetch_queue_if.slave   bus
);

   localparam int unsigned CW = $clog2(DEPTH+1);
   localparam int unsigned SW = CW + 2;

   logic [AW-1:0] fetch_pc, fetch_pc_n;
   logic [AW-1:0] head_pc, head_pc_n;
   logic [CW-1:0] live, live_n;
   logic [CW-1:0] doomed, doomed_n;
   logic [CW-1:0] occ;
   logic          err_q;

   logic [SW-1:0] outstanding;
   logic          ireq;
   logic          resp_doomed;
   logic          resp_live;
   logic          resp_err;
   logic          push;
   logic          pop;
   logic          inst_valid;
   logic [IW-1:0] head_data;

   // Request gating: buffered plus in-flight entries never exceed DEPTH.
   always_comb begin
      outstanding = SW'(occ) + SW'(live) + SW'(doomed);
      ireq        = RSTN && !bus.REDIRECT && (outstanding < SW'(DEPTH));
      resp_doomed = bus.IVALID && (doomed != '0);
      resp_live   = bus.IVALID && (doomed == '0) && (live != '0);
      resp_err    = bus.IVALID && (doomed == '0) && (live == '0);
      inst_valid  = (occ != '0);
      push        = resp_live && !bus.REDIRECT;
      pop         = inst_valid && bus.INST_READY && !bus.REDIRECT;
   end

   // Next-state for PCs and in-flight counters; redirect retires all live
   // fetches into the doomed count, minus any response landing this cycle.
   always_comb begin
      fetch_pc_n = fetch_pc;
      head_pc_n  = head_pc;
      live_n     = live;
      doomed_n   = doomed;
      if (bus.REDIRECT) begin
         fetch_pc_n = bus.REDIRECT_PC;
         head_pc_n  = bus.REDIRECT_PC;
         live_n     = '0;
         doomed_n   = CW'(live + doomed) - CW'(resp_doomed || resp_live);
      end else begin
         if (ireq) fetch_pc_n = fetch_pc + AW'(PC_INC);
         if (pop)  head_pc_n  = head_pc + AW'(PC_INC);
         live_n   = live + CW'(ireq) - CW'(resp_live);
         doomed_n = doomed - CW'(resp_doomed);
      end
   end

   // State registers; ERR is sticky until reset.
   always_ff @(posedge CLK or negedge RSTN) begin
      if (!RSTN) begin
         fetch_pc <= RESET_PC;
         head_pc  <= RESET_PC;
         live     <= '0;
         doomed   <= '0;
         err_q    <= 1'b0;
      end else begin
         fetch_pc <= fetch_pc_n;
         head_pc  <= head_pc_n;
         live     <= live_n;
         doomed   <= doomed_n;
         err_q    <= err_q | resp_err;
      end
   end

   if_inst_fifo #(
      .IW    (IW),
      .DEPTH (DEPTH)
   ) u_fifo (
      .CLK     (CLK),
      .RSTN    (RSTN),
      .push    (push),
      .pop     (pop),
      .flush   (bus.REDIRECT),
      .wr_data (bus.IRDATA),
      .rd_data (head_data),
      .occ     (occ)
   );

   assign bus.IREQ       = ireq;
   assign bus.IADDR      = fetch_pc;
   assign bus.INST_VALID = inst_valid;
   assign bus.INST       = head_data;
   assign bus.INST_PC    = head_pc;
   assign bus.ERR        = err_q;

endmodule : if_fetch_queue

// File: doc/if_fetch_queue.md
IF_FETCH_QUEUE -- requirements
Module: if_fetch_queue

Interface
REQ-001 Parameters SHALL be: AW, default 32, address width; IW, default 32, instruction width; DEPTH, default 4, buffer entries and max outstanding fetches (power of 2, 2..8); RESET_PC, default 0, PC after reset.
REQ-002 CLK  input  1  clock, rising-edge.
REQ-003 RSTN  input  1  reset, asynchronous, active-low.
REQ-004 REDIRECT  input  1  branch/jump taken; flush and refetch.
REQ-005 REDIRECT_PC  input  AW  new fetch address.
REQ-006 IREQ  output  1  fetch request to instruction memory; the memory always accepts it.
REQ-007 IADDR  output  AW  fetch address, valid while IREQ=1.
REQ-008 IVALID  input  1  memory response valid; responses return in order, latency >= 1 cycle.
REQ-009 IRDATA  input  IW  response instruction.
REQ-010 INST_VALID  output  1  buffer head valid.
REQ-011 INST  output  IW  head instruction.
REQ-012 INST_PC  output  AW  PC of head instruction.
REQ-013 INST_READY  input  1  decode accepts head (deasserted = stall).
REQ-014 ERR  output  1  sticky protocol error.

Function
REQ-015 Internal state SHALL be: fetch_pc, head_pc, occ (0..DEPTH), live (in-flight, kept), doomed (in-flight, to discard); all counters SHALL be clog2(DEPTH+1) bits.
REQ-016 IREQ SHALL be RSTN && !REDIRECT && (occ+live+doomed < DEPTH), computed combinationally; IADDR SHALL equal fetch_pc.
REQ-017 Each cycle with IREQ=1, fetch_pc SHALL advance by 4 modulo 2^AW and live SHALL increment.
REQ-018 An IVALID with doomed>0 SHALL decrement doomed and discard the data.
REQ-019 An IVALID with doomed=0 and live>0 SHALL decrement live and push IRDATA into the buffer; the entry SHALL be visible on INST the next cycle.
REQ-020 An IVALID with live=doomed=0 SHALL be ignored and SHALL set ERR until reset.
REQ-021 INST_VALID SHALL be (occ>0); a pop SHALL occur when INST_VALID && INST_READY && !REDIRECT, advancing head_pc by 4 modulo 2^AW.
REQ-022 Push and pop in the same cycle SHALL leave occ unchanged; push on full cannot occur by REQ-016.
REQ-023 On REDIRECT, at the next edge: fetch_pc and head_pc SHALL load REDIRECT_PC, occ SHALL clear, live SHALL clear, doomed SHALL become live+doomed minus 1 if IVALID in that cycle, and no pop SHALL take effect.
REQ-024 Back-to-back REDIRECT SHALL accumulate doomed correctly; the last REDIRECT_PC wins.
REQ-025 Latency SHALL be: IREQ to INST_VALID = memory latency + 1; sustained throughput one instruction/cycle with latency-1 memory and INST_READY=1.

Reset
REQ-026 While RSTN=0: IREQ=0, INST_VALID=0, ERR=0, fetch_pc=head_pc=RESET_PC, occ=live=doomed=0, INST content don't-care.
REQ-027 Reset asserted mid-operation SHALL discard all buffered and in-flight state; responses arriving after release with live=doomed=0 SHALL raise ERR (the memory shall be reset together with this block).
REQ-028 First IREQ SHALL occur in the first cycle with RSTN=1, with IADDR=RESET_PC.

Structure
REQ-029 Package if_pkg SHALL hold the default AW, IW, DEPTH, RESET_PC and the PC increment constant (4).
REQ-030 The instruction buffer SHALL be a sub-module if_inst_fifo (parameters IW, DEPTH; push, pop, flush, data, occ), circular, with pointers wrapping modulo DEPTH.

Verification (DEPTH=4, RESET_PC=0, memory returns 0xA000_0000 + address)
REQ-031 Reset release, memory latency 1, INST_READY=1 -> IADDR 0,4,8,... on consecutive cycles; INST_VALID from cycle 2 with INST_PC 0 and INST 0xA0000000, then one instruction per cycle.
REQ-032 INST_READY=0 from reset -> exactly 4 IREQ cycles (addresses 0..C), IREQ stays 0, INST_PC holds 0; raising INST_READY resumes fetch at 0x10 in order.
REQ-033 Latency 3, REDIRECT to 0x100 with 2 in flight -> next 2 IVALIDs dropped; next IADDR 0x100; first INST_PC 0x100 with INST 0xA0000100.
REQ-034 REDIRECT coincident with IVALID and INST_READY=1 -> that response dropped, no pop, occ=0 next cycle, doomed = in-flight - 1.
REQ-035 AW=8, RESET_PC=0xF8 -> IADDR F8, FC, 00, 04; INST_PC wraps identically.
REQ-036 IVALID pulse with nothing in flight -> ERR=1 and stays 1, buffer contents and occ unchanged.
